// File: rtl/memory_arbiter_pkg.sv
// Shared constants and helpers for the round-robin memory arbiter.
package memory_arbiter_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_DATA_W    = 8;

  // Width needed to index n ports (at least one bit).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of per-port request/response signals between the ports and the arbiter.
//
// Handshake: a port raises req[i] with we/addr/wdata stable and holds them until
// gnt[i] is seen high; the access commits on the rising edge where req[i] and
// gnt[i] are both high, so gnt acts as "ready" for a "valid" req. Read data
// returns on rdata with a one-cycle rvalid[i] pulse in the cycle after commit.
interface memory_arbiter_if
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [NUM_PORTS*DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/memory_arbiter_rr_arbiter.sv
// Round-robin picker: first requesting port found searching upward from ptr,
// wrapping at N. Produces a one-hot grant and the winner's index.
module rr_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int N = DEF_NUM_PORTS
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [clog2(N)-1:0]   win
);
  localparam int PTR_W = clog2(N);

  int   idx;
  logic found;

  // Rotated priority search starting at ptr.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[PTR_W-1:0]]) begin
        found                 = 1'b1;
        gnt[idx[PTR_W-1:0]]   = 1'b1;
        win                   = idx[PTR_W-1:0];
      end
    end
  end
endmodule

// File: rtl/memory_arbiter.sv
// Multi-port single-memory arbiter: one access per cycle, round-robin fairness,
// registered read data per port with a one-cycle rvalid pulse.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  memory_arbiter_if.slave               bus,
  output logic [clog2(NUM_PORTS)-1:0]   dbg_ptr
);
  localparam int PTR_W = clog2(NUM_PORTS);

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     win;
  logic [NUM_PORTS-1:0] arb_gnt, gnt_c;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q [NUM_PORTS];
  logic [DATA_W-1:0]    rdata_d [NUM_PORTS];
  logic [ADDR_W-1:0]    addr_arr [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_arr [NUM_PORTS];
  logic [DATA_W-1:0]    mem [2**ADDR_W];

  logic                 commit;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  // Unpack flat per-port buses and pack registered read data back out.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign addr_arr[g]                   = bus.addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g]                  = bus.wdata[g*DATA_W +: DATA_W];
    assign bus.rdata[g*DATA_W +: DATA_W] = rdata_q[g];
  end

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .win (win)
  );

  // Reset and disable both suppress the grant, so nothing commits in those cycles.
  assign gnt_c      = arb_gnt & {NUM_PORTS{en & ~reset}};
  assign commit     = |gnt_c;
  assign sel_we     = bus.we[win];
  assign sel_addr   = addr_arr[win];
  assign sel_wdata  = wdata_arr[win];
  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rvalid_q;
  assign dbg_ptr    = ptr_q;

  // Next pointer, read-valid pulse and read data for the committing port.
  // A write committed on the previous edge is already in mem, so no bypass is needed.
  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (commit) begin
      ptr_d = (win == PTR_W'(NUM_PORTS - 1)) ? '0 : win + PTR_W'(1);
      if (!sel_we) begin
        rvalid_d[win] = 1'b1;
        rdata_d[win]  = mem[sel_addr];
      end
    end
  end

  // Control and read-data registers; reset clears them but not the memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  // Memory write port for the committing writer.
  always_ff @(posedge clk) begin
    if (commit && sel_we) mem[sel_addr] <= sel_wdata;
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a default 4-port instance and a
// 3-port/4-bit/16-bit instance, with a read-data scoreboard per instance.
module tb_memory_arbiter;
  localparam int EW = 35; // {port[2:0], data[15:0], cycle[15:0]}

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic [1:0] ptr4;
  logic [1:0] ptr3;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [EW-1:0] exp4_q[$];
  logic [EW-1:0] exp3_q[$];

  memory_arbiter_if #(.NUM_PORTS(4), .ADDR_W(7), .DATA_W(8))  bus4 ();
  memory_arbiter_if #(.NUM_PORTS(3), .ADDR_W(4), .DATA_W(16)) bus3 ();

  memory_arbiter #(.NUM_PORTS(4), .ADDR_W(7), .DATA_W(8)) dut4 (
    .clk(clk), .reset(reset), .en(en), .bus(bus4), .dbg_ptr(ptr4)
  );

  memory_arbiter #(.NUM_PORTS(3), .ADDR_W(4), .DATA_W(16)) dut3 (
    .clk(clk), .reset(reset), .en(en), .bus(bus3), .dbg_ptr(ptr3)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(int p, bit r, bit w, logic [6:0] a, logic [7:0] d);
    bus4.req[p]          = r;
    bus4.we[p]           = w;
    bus4.addr[p*7 +: 7]  = a;
    bus4.wdata[p*8 +: 8] = d;
  endtask

  task automatic set3(int p, bit r, bit w, logic [3:0] a, logic [15:0] d);
    bus3.req[p]            = r;
    bus3.we[p]             = w;
    bus3.addr[p*4 +: 4]    = a;
    bus3.wdata[p*16 +: 16] = d;
  endtask

  task automatic clear4();
    for (int p = 0; p < 4; p++) set4(p, 1'b0, 1'b0, 7'd0, 8'd0);
  endtask

  task automatic clear3();
    for (int p = 0; p < 3; p++) set3(p, 1'b0, 1'b0, 4'd0, 16'd0);
  endtask

  // Called in the grant cycle: data is due on the next cycle.
  task automatic exp4(int p, logic [15:0] d);
    exp4_q.push_back({3'(p), d, 16'(cyc + 1)});
  endtask

  task automatic exp3(int p, logic [15:0] d);
    exp3_q.push_back({3'(p), d, 16'(cyc + 1)});
  endtask

  // monitor: every rvalid pulse must match the oldest expected read
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset !== 1'b1) begin
      for (int p = 0; p < 4; p++) begin
        if (bus4.rvalid[p] === 1'b1) begin
          checks++;
          if (exp4_q.size() == 0) begin
            errors++;
            $display("FAIL rd4_unexpected: port %0d rdata 0x%0h with nothing expected", p, bus4.rdata[p*8 +: 8]);
          end else begin
            e = exp4_q.pop_front();
            if (e[34:32] != 3'(p) || e[31:16] != {8'd0, bus4.rdata[p*8 +: 8]} || e[15:0] != 16'(cyc)) begin
              errors++;
              $display("FAIL rd4: got port %0d data 0x%0h cycle %0d, expected port %0d data 0x%0h cycle %0d",
                       p, bus4.rdata[p*8 +: 8], cyc, e[34:32], e[31:16], e[15:0]);
            end
          end
        end
      end
      for (int p = 0; p < 3; p++) begin
        if (bus3.rvalid[p] === 1'b1) begin
          checks++;
          if (exp3_q.size() == 0) begin
            errors++;
            $display("FAIL rd3_unexpected: port %0d rdata 0x%0h with nothing expected", p, bus3.rdata[p*16 +: 16]);
          end else begin
            e = exp3_q.pop_front();
            if (e[34:32] != 3'(p) || e[31:16] != bus3.rdata[p*16 +: 16] || e[15:0] != 16'(cyc)) begin
              errors++;
              $display("FAIL rd3: got port %0d data 0x%0h cycle %0d, expected port %0d data 0x%0h cycle %0d",
                       p, bus3.rdata[p*16 +: 16], cyc, e[34:32], e[31:16], e[15:0]);
            end
          end
        end
      end
    end
  end

  // directed stimulus
  initial begin
    int p;
    int waited;
    reset = 1'b1;
    en    = 1'b1;
    clear4();
    clear3();
    bus4.req = 4'b1111;

    // reset: grants masked, registers cleared
    tick();
    @(negedge clk);
    chk("rst_gnt", 32'(bus4.gnt), 32'h0);
    chk("rst_ptr", 32'(ptr4), 32'h0);
    chk("rst_rvalid", 32'(bus4.rvalid), 32'h0);
    chk("rst_rdata", bus4.rdata, 32'h0);
    tick();
    reset = 1'b0;
    clear4();

    // port0 writes 10 -> addr 10, port1 reads it back
    set4(0, 1, 1, 7'd10, 8'h0A);
    @(negedge clk); chk("t1_wr_gnt", 32'(bus4.gnt), 32'h1);
    tick();
    set4(0, 0, 0, 7'd0, 8'd0);
    set4(1, 1, 0, 7'd10, 8'd0);
    @(negedge clk); chk("t1_rd_gnt", 32'(bus4.gnt), 32'h2); chk("t1_ptr", 32'(ptr4), 32'h1); exp4(1, 16'h0A);
    tick();
    set4(1, 0, 0, 7'd0, 8'd0);

    // back-to-back write then read of the same address
    set4(2, 1, 1, 7'd5, 8'hA5);
    @(negedge clk); chk("t2_wr_gnt", 32'(bus4.gnt), 32'h4);
    tick();
    set4(2, 0, 0, 7'd0, 8'd0);
    set4(3, 1, 0, 7'd5, 8'd0);
    @(negedge clk); chk("t2_rd_gnt", 32'(bus4.gnt), 32'h8); exp4(3, 16'hA5);
    tick();
    set4(3, 0, 0, 7'd0, 8'd0);

    // four simultaneous writers served 0,1,2,3; each drops req once granted
    for (int i = 0; i < 4; i++) set4(i, 1, 1, 7'(20 + i), 8'((i + 1) * 17));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("t3_wr_gnt", 32'(bus4.gnt), 32'(1 << k));
      tick();
      set4(k, 0, 0, 7'd0, 8'd0);
    end

    // four continuous readers: grants 0,1,2,3,0
    for (int i = 0; i < 4; i++) set4(i, 1, 0, 7'(20 + i), 8'd0);
    for (int k = 0; k < 5; k++) begin
      p = k % 4;
      @(negedge clk); chk("t3_rd_gnt", 32'(bus4.gnt), 32'(1 << p)); exp4(p, 16'((p + 1) * 17));
      tick();
    end
    clear4();
    @(negedge clk); chk("t3_ptr", 32'(ptr4), 32'h1); chk("hold_rdata3", 32'(bus4.rdata[3*8 +: 8]), 32'h44);
    tick();

    // disabled for three cycles with all ports requesting
    en = 1'b0;
    for (int i = 0; i < 4; i++) set4(i, 1, 0, 7'(20 + i), 8'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_gnt_off", 32'(bus4.gnt), 32'h0);
      chk("t4_ptr_off", 32'(ptr4), 32'h1);
      chk("t4_rvalid_off", 32'(bus4.rvalid), 32'h0);
      tick();
    end
    en = 1'b1;
    @(negedge clk); chk("t4_resume_gnt", 32'(bus4.gnt), 32'h2); exp4(1, 16'h22);
    tick();
    clear4();

    // port0 gives up before being granted: its write must not land
    set4(2, 1, 1, 7'd30, 8'h55);
    set4(0, 1, 1, 7'd30, 8'h77);
    @(negedge clk); chk("t5_gnt", 32'(bus4.gnt), 32'h4);
    tick();
    clear4();
    set4(3, 1, 0, 7'd30, 8'd0);
    @(negedge clk); chk("t5_rd_gnt", 32'(bus4.gnt), 32'h8); exp4(3, 16'h55);
    tick();
    clear4();

    // reset aborts a granted write
    set4(0, 1, 1, 7'd7, 8'h12);
    @(negedge clk); chk("t6_wr_gnt", 32'(bus4.gnt), 32'h1);
    tick();
    clear4();
    set4(1, 1, 1, 7'd7, 8'h3C);
    reset = 1'b1;
    @(negedge clk); chk("t6_rst_gnt", 32'(bus4.gnt), 32'h0);
    tick();
    reset = 1'b0;
    clear4();
    @(negedge clk);
    chk("t6_ptr", 32'(ptr4), 32'h0);
    chk("t6_rvalid", 32'(bus4.rvalid), 32'h0);
    chk("t6_rdata", bus4.rdata, 32'h0);
    tick();
    set4(2, 1, 0, 7'd7, 8'd0);
    @(negedge clk); chk("t6_rd_gnt", 32'(bus4.gnt), 32'h4); exp4(2, 16'h12);
    tick();
    clear4();

    // 3-port instance: wrap of the pointer and full-width data
    set3(2, 1, 1, 4'd15, 16'hBEEF);
    @(negedge clk); chk("t7_wr_gnt", 32'(bus3.gnt), 32'h4);
    tick();
    set3(2, 1, 0, 4'd15, 16'd0);
    @(negedge clk); chk("t7_ptr_wrap", 32'(ptr3), 32'h0); chk("t7_rd_gnt", 32'(bus3.gnt), 32'h4); exp3(2, 16'hBEEF);
    tick();
    set3(0, 1, 0, 4'd15, 16'd0);
    @(negedge clk); chk("t7_rd0_gnt", 32'(bus3.gnt), 32'h1); exp3(0, 16'hBEEF);
    tick();
    set3(0, 0, 0, 4'd0, 16'd0);
    @(negedge clk); chk("t7_rd2_gnt", 32'(bus3.gnt), 32'h4); exp3(2, 16'hBEEF);
    tick();
    clear3();

    // let outstanding reads drain, bounded
    waited = 0;
    while ((exp4_q.size() != 0 || exp3_q.size() != 0) && waited < 10) begin
      tick();
      waited++;
    end
    @(negedge clk);
    chk("drain4", 32'(exp4_q.size()), 32'h0);
    chk("drain3", 32'(exp3_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
